// File: rtl/dvs_event_packer.sv
// dvs_event_packer: buffers single-cycle DVS events in a small FIFO and
// streams each one as a header word followed by a timestamp word.
// Optional build macro: DVS_PACKER_TS_DELTA_EN makes the timestamp word carry
// the difference to the previously emitted event instead of the absolute time.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | output register empty; pop the next event when one is stored
// S_HDR  | presenting the header word (valid, not last)
// S_TS   | presenting the timestamp word (valid, last)
module dvs_event_packer #(
  parameter int X_BITS     = 9,
  parameter int Y_BITS     = 9,
  parameter int TS_BITS    = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [X_BITS-1:0]             event_x,
  input  logic [Y_BITS-1:0]             event_y,
  input  logic [TS_BITS-1:0]            event_timestamp,
  input  logic                          event_polarity,
  input  logic                          new_event,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 1 + Y_BITS + X_BITS + TS_BITS;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TS} state_t;

  state_t              state, state_nx;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [EW-1:0]       out_entry;
  logic                fifo_empty, fifo_full;
  logic                pop, push_ok, drop;
  logic [TS_BITS-1:0]  cur_ts;
  logic [X_BITS-1:0]   cur_x;
  logic [Y_BITS-1:0]   cur_y;
  logic                cur_pol;
  logic [31:0]         hdr_word, ts_word;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LEVEL);
  // A full FIFO still takes the event when the output side frees a slot this cycle.
  assign push_ok    = new_event && (!fifo_full || pop);
  assign drop       = new_event && !push_ok;

  assign cur_ts  = out_entry[TS_BITS-1:0];
  assign cur_x   = out_entry[TS_BITS +: X_BITS];
  assign cur_y   = out_entry[TS_BITS+X_BITS +: Y_BITS];
  assign cur_pol = out_entry[EW-1];

  assign hdr_word = {1'b1, 6'b0, cur_pol, 12'(cur_y), 12'(cur_x)};

`ifdef DVS_PACKER_TS_DELTA_EN
  logic [TS_BITS-1:0] ts_base;
  logic [TS_BITS-1:0] ts_delta;

  assign ts_delta = cur_ts - ts_base;
  assign ts_word  = 32'(ts_delta);

  // Base follows the last event whose timestamp word was accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ts_base <= '0;
    else if (state == S_TS && out_ready)
      ts_base <= cur_ts;
  end
`else
  assign ts_word = 32'(cur_ts);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next state, pop request and stream outputs.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = S_HDR;
        end
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_word;
        if (out_ready)
          state_nx = S_TS;
      end
      S_TS: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = ts_word;
        if (out_ready) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_nx = S_HDR;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {event_polarity, event_y, event_x, event_timestamp};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output register holds the event being serialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_entry <= '0;
    else if (pop)
      out_entry <= mem[rd_ptr];
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dvs_event_packer.sv
// Self-checking bench for dvs_event_packer: constant vector table, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_dvs_event_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  event_x = '0;
  logic [8:0]  event_y = '0;
  logic [31:0] event_timestamp = '0;
  logic        event_polarity = 1'b0;
  logic        new_event = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_count;

  dvs_event_packer #(.X_BITS(9), .Y_BITS(9), .TS_BITS(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .event_x(event_x), .event_y(event_y), .event_timestamp(event_timestamp),
    .event_polarity(event_polarity), .new_event(new_event),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: events waiting in the FIFO, plus the words still to be
  // sent for the event currently owned by the output stage.
  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic        pol;
    logic [31:0] ts;
  } evt_t;

  evt_t        fifo_q[$];
  logic [31:0] word_q[$];
  logic [31:0] m_cur_ts;
  logic [31:0] m_base;
  bit          m_ovf;
  int          m_drops;

  logic [31:0] obs_data;
  logic        obs_valid, obs_last;
  logic [4:0]  obs_level;

  function automatic logic [31:0] header_of(evt_t e);
    return 32'h8000_0000 + (32'(e.pol) * 32'h0100_0000) + (32'(e.y) * 32'd4096) + 32'(e.x);
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    word_q.delete();
    m_cur_ts = '0;
    m_base   = '0;
    m_ovf    = 0;
    m_drops  = 0;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input bit ne, input bit rdy, input logic [8:0] x, input logic [8:0] y,
                      input bit pol, input logic [31:0] ts);
    bit   hs, do_pop;
    evt_t e;
    new_event = ne; out_ready = rdy;
    event_x = x; event_y = y; event_polarity = pol; event_timestamp = ts;
    @(negedge clk);
    obs_data = out_data; obs_valid = out_valid; obs_last = out_last; obs_level = fifo_level;
    chk("valid", 32'(out_valid), 32'(word_q.size() > 0));
    if (word_q.size() > 0) begin
      chk("data", out_data, word_q[0]);
      chk("last", 32'(out_last), 32'(word_q.size() == 1));
    end
    chk("level", 32'(fifo_level), 32'(fifo_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    hs = (word_q.size() > 0) && rdy;
    if (hs) begin
      if (word_q.size() == 1) m_base = m_cur_ts;
      void'(word_q.pop_front());
    end
    do_pop = (word_q.size() == 0) && (fifo_q.size() > 0);
    if (do_pop) begin
      e = fifo_q.pop_front();
      m_cur_ts = e.ts;
      word_q.push_back(header_of(e));
`ifdef DVS_PACKER_TS_DELTA_EN
      word_q.push_back(e.ts - m_base);
`else
      word_q.push_back(e.ts);
`endif
    end
    if (ne) begin
      if (fifo_q.size() < DEPTH) begin
        e.x = x; e.y = y; e.pol = pol; e.ts = ts;
        fifo_q.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drops != 65535) m_drops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, rdy, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    new_event = 0; out_ready = 0;
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  typedef struct {
    bit          ne;
    bit          rdy;
    logic [8:0]  x;
    logic [8:0]  y;
    bit          pol;
    logic [31:0] ts;
    bit          ev;
    logic [31:0] ed;
    bit          el;
    int          elev;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // single event: header two cycles after the strobe, then timestamp, then idle
    tbl[0] = '{ne:1, rdy:1, x:9'd5, y:9'd7, pol:1, ts:32'd1000, ev:0, ed:32'h0, el:0, elev:0};
    tbl[1] = '{ne:0, rdy:1, x:9'd0, y:9'd0, pol:0, ts:32'd0, ev:0, ed:32'h0, el:0, elev:1};
    tbl[2] = '{ne:0, rdy:1, x:9'd0, y:9'd0, pol:0, ts:32'd0, ev:1, ed:32'h8100_7005, el:0, elev:0};
    tbl[3] = '{ne:0, rdy:1, x:9'd0, y:9'd0, pol:0, ts:32'd0, ev:1, ed:32'd1000, el:1, elev:0};
    tbl[4] = '{ne:0, rdy:1, x:9'd0, y:9'd0, pol:0, ts:32'd0, ev:0, ed:32'h0, el:0, elev:0};

    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      step(tbl[i].ne, tbl[i].rdy, tbl[i].x, tbl[i].y, tbl[i].pol, tbl[i].ts);
      chk("tbl_valid", 32'(obs_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_data", obs_data, tbl[i].ed);
      chk("tbl_last", 32'(obs_last), 32'(tbl[i].el));
      chk("tbl_level", 32'(obs_level), 32'(tbl[i].elev));
    end

    // back-pressure: header held for 10 stalled cycles
    do_reset();
    step(1, 0, 9'd300, 9'd17, 0, 32'd555);
    idle(0, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, '0, 0, '0);
      chk("bp_hold_data", obs_data, 32'h8001_112C);
      chk("bp_hold_valid", 32'(obs_valid), 32'd1);
    end
    step(0, 1, '0, '0, 0, '0);
    chk("bp_hdr_accept", obs_data, 32'h8001_112C);
    step(0, 1, '0, '0, 0, '0);
    chk("bp_ts_word", obs_data, 32'd555);
    chk("bp_ts_last", 32'(obs_last), 32'd1);
    idle(1, 2);

    // fill: 18 strobes with the output stalled, then push+pop on a full FIFO
    do_reset();
    for (int i = 0; i < 18; i++) step(1, 0, 9'(i + 1), 9'(2 * i), i[0], 32'(1000 + 7 * i));
    step(0, 0, '0, '0, 0, '0);
    chk("fill_level", 32'(obs_level), 32'd16);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_drops", 32'(drop_count), 32'd1);
    step(0, 1, '0, '0, 0, '0);
    step(1, 1, 9'd77, 9'd88, 1, 32'd4242);
    step(0, 0, '0, '0, 0, '0);
    chk("fullpp_level", 32'(obs_level), 32'd16);
    chk("fullpp_drops", 32'(drop_count), 32'd1);
    idle(1, 40);

    // reset while the timestamp word is stalled
    do_reset();
    step(1, 0, 9'd9, 9'd3, 1, 32'd77);
    idle(0, 2);
    step(0, 1, '0, '0, 0, '0);
    step(0, 0, '0, '0, 0, '0);
    chk("mid_last_before", 32'(obs_last), 32'd1);
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    step(1, 1, 9'd1, 9'd2, 0, 32'd12345);
    idle(1, 1);
    step(0, 1, '0, '0, 0, '0);
    chk("post_rst_hdr", obs_data, 32'h8000_2001);
    step(0, 1, '0, '0, 0, '0);
    chk("post_rst_ts", obs_data, 32'd12345);
    idle(1, 2);

`ifdef DVS_PACKER_TS_DELTA_EN
    do_reset();
    step(1, 1, 9'd4, 9'd4, 0, 32'd100);
    idle(1, 2);
    step(0, 1, '0, '0, 0, '0);
    chk("delta_first", obs_data, 32'd100);
    step(1, 1, 9'd4, 9'd4, 0, 32'd130);
    idle(1, 2);
    step(0, 1, '0, '0, 0, '0);
    chk("delta_second", obs_data, 32'd30);
    step(1, 1, 9'd4, 9'd4, 0, 32'hFFFF_FFF0);
    idle(1, 3);
    step(1, 1, 9'd4, 9'd4, 0, 32'h0000_0010);
    idle(1, 2);
    step(0, 1, '0, '0, 0, '0);
    chk("delta_wrap", obs_data, 32'h20);
    idle(1, 2);
`endif

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, ($urandom % 4) != 0 || (i > 2000 && ($urandom % 2) != 0),
           9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom % 2), $urandom);
    end
    idle(1, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
